// File: rtl/odd_parity_checker.sv
// odd_parity_checker: serial frame receiver (start, LSB-first data, odd parity, stop) with error flags and saturating error count
module odd_parity_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;
  logic [1:0]        state;
  logic [4:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              perr_next;
  assign busy      = state != IDLE;
  assign perr_next = ~(^shreg ^ par);
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (!in) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: begin
          shreg   <= DATA_W'({in, shreg} >> 1);
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'(DATA_W - 1)) state <= PARITY;
        end
        PARITY: begin
          par   <= in;
          state <= STOP;
        end
        default: begin
          state      <= IDLE;
          valid      <= 1'b1;
          data_out   <= shreg;
          parity_err <= perr_next;
          frame_err  <= ~in;
          if (perr_next && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
      endcase
    end
  end
endmodule
